// File: rtl/mac_dot_seq.sv
// Sequential dot-product controller around a combinational MAC (out = A*B + C).
// Optional build macro MAC_SATURATE_EN clamps the accumulator on unsigned wrap.
module mac_dot_seq #(
  parameter int unsigned WIDTH_A = 5,
  parameter int unsigned WIDTH_B = 7,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         in_A,
  input  logic [WIDTH_B-1:0]         in_B,
  input  logic                       in_last,
  output logic [WIDTH_A-1:0]         mac_A,
  output logic [WIDTH_B-1:0]         mac_B,
  output logic [WIDTH_A+WIDTH_B-1:0] mac_C,
  input  logic [WIDTH_A+WIDTH_B-1:0] mac_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] out_data,
  output logic [CNT_W-1:0]           out_count,
  output logic                       out_ovf
);

  localparam int unsigned ACC_W = WIDTH_A + WIDTH_B;

`ifdef MAC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic beat;
  logic wrap;

  // Operands pass straight through; the accumulator closes the loop via C.
  assign mac_A = in_A;
  assign mac_B = in_B;
  assign mac_C = acc_q;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

  // The product always fits ACC_W bits, so a result below C means the add wrapped.
  assign beat = in_valid & (state_q == ST_ACC);
  assign wrap = (mac_out < mac_C);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_ACC: begin
        if (beat) begin
          acc_d   = (SAT_EN && wrap) ? {ACC_W{1'b1}} : mac_out;
          count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
          ovf_d   = ovf_q | wrap;
          if (in_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    // Abort wins over any beat or handoff in the same cycle.
    if (clr) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      state_d = ST_ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq; a behavioural MAC closes the A*B+C loop.
module tb_mac_dot_seq;

  localparam int unsigned WIDTH_A = 5;
  localparam int unsigned WIDTH_B = 7;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ACC_W   = WIDTH_A + WIDTH_B;
  localparam int          ACC_MAX = (1 << ACC_W) - 1;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

`ifdef MAC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef struct {
    int data;
    int count;
    int ovf;
  } result_t;

  logic               clk = 1'b0;
  logic               rst_n, clr, in_valid, in_ready, in_last;
  logic [WIDTH_A-1:0] in_A, mac_A;
  logic [WIDTH_B-1:0] in_B, mac_B;
  logic [ACC_W-1:0]   mac_C, mac_out, out_data;
  logic               out_valid, out_ready, out_ovf;
  logic [CNT_W-1:0]   out_count;

  int n_chk = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_push = 0;

  result_t sb_q[$];
  int m_acc = 0, m_cnt = 0, m_ovf = 0;

  always #5 clk = ~clk;

  assign mac_out = ACC_W'(32'(mac_A) * 32'(mac_B) + 32'(mac_C));

  mac_dot_seq #(.WIDTH_A(WIDTH_A), .WIDTH_B(WIDTH_B), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_last(in_last),
    .mac_A(mac_A), .mac_B(mac_B), .mac_C(mac_C), .mac_out(mac_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 0;
  endtask

  // Called and returns at posedge+1; advances the reference model on acceptance.
  task automatic send(input int a, input int b, input bit last);
    int  sum;
    bit  got;
    result_t r;
    in_valid = 1'b1;
    in_A = WIDTH_A'(a);
    in_B = WIDTH_B'(b);
    in_last = last;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) chk("in_ready_timeout", 0, 1);
    sum = m_acc + a * b;
    if (sum > ACC_MAX) begin
      m_ovf = 1;
      m_acc = SAT_EN ? ACC_MAX : (sum & ACC_MAX);
    end else begin
      m_acc = sum;
    end
    if (m_cnt < CNT_MAX) m_cnt++;
    if (last) begin
      r.data = m_acc; r.count = m_cnt; r.ovf = m_ovf;
      sb_q.push_back(r);
      n_push++;
      model_clear();
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_count"}, int'(out_count), 0);
    chk({tag, "_ovf"}, int'(out_ovf), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_ready"}, int'(in_ready), 1);
  endtask

  // Result monitor: a handoff happens at the next edge, so compare against the scoreboard.
  always @(negedge clk) begin
    result_t e;
    if (rst_n === 1'b1 && clr === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        chk("out_data", int'(out_data), e.data);
        chk("out_count", int'(out_count), e.count);
        chk("out_ovf", int'(out_ovf), e.ovf);
      end
    end
  end

  initial begin
    int d0, c0, o0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_A = '0; in_B = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Two-beat stream; result visible one cycle after the last beat.
    send(13, 23, 1'b0);
    chk("mac_A_pass", int'(mac_A), 13);
    send(15, 21, 1'b1);
    chk("latency_valid", int'(out_valid), 1);
    chk("done_in_ready", int'(in_ready), 0);
    idle(1);
    chk("handoff_valid", int'(out_valid), 0);

    // Single beat, then a stream that must start from zero.
    send(1, 1, 1'b1);
    send(2, 2, 1'b1);

    // Wrapping stream.
    send(31, 127, 1'b0);
    send(31, 127, 1'b1);
    idle(2);

    // Backpressure: three stalled cycles, accept on the fourth.
    out_ready = 1'b0;
    send(4, 5, 1'b0);
    send(6, 7, 1'b1);
    d0 = int'(out_data); c0 = int'(out_count); o0 = int'(out_ovf);
    in_valid = 1'b1; in_A = 5'd9; in_B = 7'd9;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_data", int'(out_data), d0);
      chk("bp_count", int'(out_count), c0);
      chk("bp_ovf", int'(out_ovf), o0);
      idle(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(1);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);

    // Abort after two of four beats.
    send(10, 10, 1'b0);
    send(11, 11, 1'b0);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    model_clear();
    check_zero("clr");
    send(2, 3, 1'b1);
    idle(2);

    // Reset and clr together mid-stream.
    send(7, 7, 1'b0);
    rst_n = 1'b0; clr = 1'b1;
    idle(1);
    rst_n = 1'b1; clr = 1'b0;
    model_clear();
    check_zero("rst_mid");

    // Reset while holding a wrapped result in DONE.
    out_ready = 1'b0;
    send(31, 127, 1'b0);
    send(31, 127, 1'b1);
    chk("pre_rst_ovf", int'(out_ovf), 1);
    rst_n = 1'b0;
    void'(sb_q.pop_back());
    n_push--;
    idle(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    check_zero("rst_done");

    // Beat counter saturation.
    for (int i = 0; i < 300; i++) send(0, 0, i == 299);
    idle(2);

    // Random streams with idle gaps.
    for (int s = 0; s < 12; s++) begin
      int len;
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        idle(int'($urandom_range(0, 2)));
        send(int'($urandom_range(0, 31)), int'($urandom_range(0, 127)), k == len - 1);
      end
    end
    idle(4);

    chk("sb_drained", sb_q.size(), 0);
    chk("pop_count", n_pop, n_push);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
